// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory responder: stalls the core while a fixed-latency
// word-wide RAM is accessed, with byte/half lane steering and load extension.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        CPU_RESETN,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    output logic [31:0] mem_rd_o,
    output logic        stall_o,
    output logic        misaligned_o
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_W = IDX_W + 2;
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         size_q, size_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wd_q, wd_d;
    logic [31:0]        rd_d;
    logic               mis_d;
    logic               store_c;
    logic [31:0]        word_c;
    logic [31:0]        load_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the array span are ignored, so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^mem_addr_i[31:ADDR_W];

    function automatic logic is_illegal(input logic we, input logic [2:0] size,
                                        input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_BU:   bad = we;
            SZ_H:    bad = a[0];
            SZ_HU:   bad = we | a[0];
            SZ_W:    bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign stall_o = mem_req_i & (state != DONE);

    // Load path: select the lane of the addressed word and extend it.
    always_comb begin
        word_c = mem[addr_q[ADDR_W-1:2]];
        byte_c = word_c[7:0];
        half_c = addr_q[1] ? word_c[31:16] : word_c[15:0];
        case (addr_q[1:0])
            2'b01:   byte_c = word_c[15:8];
            2'b10:   byte_c = word_c[23:16];
            2'b11:   byte_c = word_c[31:24];
            default: byte_c = word_c[7:0];
        endcase
        case (size_q)
            SZ_B:    load_c = {{24{byte_c[7]}}, byte_c};
            SZ_BU:   load_c = {24'h000000, byte_c};
            SZ_H:    load_c = {{16{half_c[15]}}, half_c};
            SZ_HU:   load_c = {16'h0000, half_c};
            default: load_c = word_c;
        endcase
    end

    // Store path: replicate right-aligned data across lanes, enable the target bytes.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wd_q;
        case (size_q)
            SZ_B: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{wd_q[7:0]}};
            end
            SZ_H: begin
                be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wd_q[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wd_q;
            end
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = mem_rd_o;
        mis_d   = 1'b0;
        store_c = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i) begin
                    we_d   = mem_we_i;
                    size_d = mem_size_i;
                    addr_d = mem_addr_i[ADDR_W-1:0];
                    wd_d   = mem_wd_i;
                    if (is_illegal(mem_we_i, mem_size_i, mem_addr_i[1:0])) begin
                        rd_d    = 32'h0;
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    if (we_q) begin
                        store_c = 1'b1;
                    end else begin
                        rd_d = load_c;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            size_q       <= 3'b000;
            addr_q       <= '0;
            wd_q         <= 32'h0;
            mem_rd_o     <= 32'h0;
            misaligned_o <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            mem_rd_o     <= rd_d;
            misaligned_o <= mis_d;
        end
    end

    // Array has no reset; a store only commits from the final ACCESS cycle.
    always_ff @(posedge CLK) begin
        if (store_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wdata_c[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus random traffic checked
// against a byte-addressed reference memory.
module tb_data_mem_ctrl;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int BYTES = 4 * DEPTH;

    logic        CLK = 1'b0;
    logic        CPU_RESETN;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [2:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wd_i;
    logic [31:0] mem_rd_o;
    logic        stall_o;
    logic        misaligned_o;

    int tests = 0;
    int fails = 0;

    logic [7:0]  ref_mem [BYTES];
    logic [31:0] exp_rd;
    logic [31:0] last_rd;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK          (CLK),
        .CPU_RESETN   (CPU_RESETN),
        .mem_req_i    (mem_req_i),
        .mem_we_i     (mem_we_i),
        .mem_size_i   (mem_size_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wd_i     (mem_wd_i),
        .mem_rd_o     (mem_rd_o),
        .stall_o      (stall_o),
        .misaligned_o (misaligned_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request through the DUT, with expectations derived from the byte model.
    task automatic access(input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic illegal;
        int   a;
        int   stalls;
        a = int'(addr[11:0]);
        illegal = (size == 3'd3) || (size == 3'd6) || (size == 3'd7)
               || (we && (size == 3'd4 || size == 3'd5))
               || ((size == 3'd1 || size == 3'd5) && (a % 2 != 0))
               || ((size == 3'd2) && (a % 4 != 0));
        if (illegal) begin
            exp_rd = 32'h0;
        end else if (we) begin
            ref_mem[a] = wd[7:0];
            if (size != 3'd0) ref_mem[a+1] = wd[15:8];
            if (size == 3'd2) begin
                ref_mem[a+2] = wd[23:16];
                ref_mem[a+3] = wd[31:24];
            end
        end else begin
            case (size)
                3'd0: exp_rd = {{24{ref_mem[a][7]}}, ref_mem[a]};
                3'd4: exp_rd = {24'h0, ref_mem[a]};
                3'd1: exp_rd = {{16{ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
                3'd5: exp_rd = {16'h0, ref_mem[a+1], ref_mem[a]};
                default: exp_rd = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
            endcase
        end

        @(negedge CLK);
        mem_req_i  = 1'b1;
        mem_we_i   = we;
        mem_size_i = size;
        mem_addr_i = addr;
        mem_wd_i   = wd;
        #1;
        stalls = 0;
        while (stall_o === 1'b1 && stalls < 16) begin
            stalls++;
            @(negedge CLK);
        end
        check("stall_cycles", 32'(stalls), illegal ? 32'd1 : 32'(LAT + 1));
        check("rd_data", mem_rd_o, exp_rd);
        check("misaligned", {31'h0, misaligned_o}, {31'h0, illegal});
        last_rd   = mem_rd_o;
        mem_req_i = 1'b0;
        @(negedge CLK);
        check("misaligned_clear", {31'h0, misaligned_o}, 32'h0);
    endtask

    initial begin
        CPU_RESETN = 1'b0;
        mem_req_i  = 1'b0;
        mem_we_i   = 1'b0;
        mem_size_i = 3'd0;
        mem_addr_i = 32'h0;
        mem_wd_i   = 32'h0;
        exp_rd     = 32'h0;
        last_rd    = 32'h0;

        // Reset values; stall follows the request while in reset.
        repeat (2) @(negedge CLK);
        check("rst_rd", mem_rd_o, 32'h0);
        check("rst_mis", {31'h0, misaligned_o}, 32'h0);
        check("rst_stall_lo", {31'h0, stall_o}, 32'h0);
        mem_req_i = 1'b1;
        #1;
        check("rst_stall_hi", {31'h0, stall_o}, 32'h1);
        mem_req_i = 1'b0;
        @(negedge CLK);
        CPU_RESETN = 1'b1;

        // Word store/load.
        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        access(1'b0, 3'd2, 32'h10, 32'h0);
        check("s1_lw", last_rd, 32'hDEADBEEF);

        // Byte and half lanes with extension.
        access(1'b1, 3'd0, 32'h13, 32'h00000080);
        access(1'b0, 3'd0, 32'h13, 32'h0);
        check("s2_lb", last_rd, 32'hFFFFFF80);
        access(1'b0, 3'd4, 32'h13, 32'h0);
        check("s2_lbu", last_rd, 32'h00000080);
        access(1'b0, 3'd2, 32'h10, 32'h0);
        check("s2_lw", last_rd, 32'h80ADBEEF);
        access(1'b1, 3'd1, 32'h12, 32'h00007FFF);
        access(1'b0, 3'd1, 32'h12, 32'h0);
        check("s2_lh", last_rd, 32'h00007FFF);

        // Misaligned requests leave memory intact.
        access(1'b0, 3'd1, 32'h11, 32'h0);
        check("s3_lh_mis_rd", last_rd, 32'h0);
        access(1'b1, 3'd2, 32'h12, 32'hFFFFFFFF);
        access(1'b0, 3'd2, 32'h10, 32'h0);
        check("s3_lw", last_rd, 32'h7FFFBEEF);

        // Reset during ACCESS aborts the store.
        access(1'b1, 3'd2, 32'h20, 32'h0);
        @(negedge CLK);
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b1;
        mem_size_i = 3'd2;
        mem_addr_i = 32'h20;
        mem_wd_i   = 32'h12345678;
        @(negedge CLK);
        CPU_RESETN = 1'b0;
        #1;
        check("s4_rst_rd", mem_rd_o, 32'h0);
        check("s4_rst_mis", {31'h0, misaligned_o}, 32'h0);
        check("s4_rst_stall", {31'h0, stall_o}, 32'h1);
        mem_req_i = 1'b0;
        #1;
        check("s4_rst_stall_lo", {31'h0, stall_o}, 32'h0);
        exp_rd = 32'h0;
        @(negedge CLK);
        CPU_RESETN = 1'b1;
        access(1'b0, 3'd2, 32'h20, 32'h0);
        check("s4_lw", last_rd, 32'h0);

        // Address wrap-around.
        access(1'b1, 3'd2, 32'h1000, 32'hA5A5A5A5);
        access(1'b0, 3'd2, 32'h0, 32'h0);
        check("s5_wrap", last_rd, 32'hA5A5A5A5);

        // Request held high across two back-to-back loads.
        access(1'b1, 3'd2, 32'h14, 32'hCAFEF00D);
        @(negedge CLK);
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_size_i = 3'd2;
        mem_addr_i = 32'h10;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge CLK);
            check($sformatf("s6_stall_c%0d", c), {31'h0, stall_o},
                  (c == 3 || c == 7) ? 32'h0 : 32'h1);
            if (c == 3) begin
                check("s6_rd_first", mem_rd_o, 32'h7FFFBEEF);
                mem_addr_i = 32'h14;
            end
            if (c == 7) check("s6_rd_second", mem_rd_o, 32'hCAFEF00D);
        end
        mem_req_i = 1'b0;
        exp_rd    = 32'hCAFEF00D;

        // Random traffic over a small region, with random upper address bits.
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 3'd2, 32'h100 + 32'(4 * i), $urandom);
        end
        for (int i = 0; i < 80; i++) begin
            logic        we;
            logic [2:0]  size;
            logic [31:0] addr;
            we   = 1'($urandom_range(0, 1));
            size = 3'($urandom_range(0, 7));
            addr = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
            access(we, size, addr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
